// File: rtl/stage_f_queue_if.sv
// rtl/stage_f_queue_if.sv - F-bus, redirect and decode handshake bundle for the prefetch queue.
interface stage_f_queue_if #(
  parameter int ADR_WIDTH = 64
);
  logic                 f_cyc_o;
  logic                 f_ack_i;
  logic [ADR_WIDTH-3:0] f_adr_o;
  logic [31:0]          f_dat_i;
  logic                 redir_i;
  logic [ADR_WIDTH-3:0] redir_adr_i;
  logic                 d_valid_o;
  logic                 d_ready_i;
  logic [31:0]          d_inst_o;
  logic [ADR_WIDTH-3:0] d_pc_o;

  // master is the fetch stage itself; slave is the bus/decode environment.
  modport master (
    output f_cyc_o, f_adr_o, d_valid_o, d_inst_o, d_pc_o,
    input  f_ack_i, f_dat_i, redir_i, redir_adr_i, d_ready_i
  );

  modport slave (
    input  f_cyc_o, f_adr_o, d_valid_o, d_inst_o, d_pc_o,
    output f_ack_i, f_dat_i, redir_i, redir_adr_i, d_ready_i
  );
endinterface

// File: rtl/stage_f_queue.sv
// rtl/stage_f_queue.sv - sequential instruction fetch into a DEPTH-entry {inst, pc} prefetch queue.
// Optional same-cycle ack-to-decode bypass when the queue is empty: STAGE_F_BYPASS_EN.
module stage_f_queue #(
  parameter int          ADR_WIDTH    = 64,
  parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00,
  parameter int          DEPTH        = 4,
  parameter int          DEPTH_LOG2   = 2
) (
  input logic            clk_i,
  input logic            reset_i,
  stage_f_queue_if.master bus
);
  localparam int AW = ADR_WIDTH - 2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [AW-1:0] RESET_PC = RESET_VECTOR[ADR_WIDTH-1:2];

  logic [AW-1:0]         pc;
  logic                  run;
  logic [31:0]           inst_mem [DEPTH];
  logic [AW-1:0]         pc_mem   [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic f_cyc;
  logic queued;
  logic push;
  logic pop;
  logic wr_en;

  assign f_cyc  = run && (count != FULL);
  assign queued = (count != '0);
  assign push   = f_cyc && bus.f_ack_i && !bus.redir_i;
  assign pop    = queued && bus.d_ready_i && !bus.redir_i;

  assign bus.f_cyc_o = f_cyc;
  assign bus.f_adr_o = pc;

`ifdef STAGE_F_BYPASS_EN
  logic bypass;

  // An empty queue hands the acked word straight to decode; it is stored only if decode stalls.
  assign bypass        = push && !queued;
  assign wr_en         = push && !(bypass && bus.d_ready_i);
  assign bus.d_valid_o = queued || bypass;
  assign bus.d_inst_o  = bypass ? bus.f_dat_i : inst_mem[rd_ptr];
  assign bus.d_pc_o    = bypass ? pc : pc_mem[rd_ptr];
`else
  assign wr_en         = push;
  assign bus.d_valid_o = queued;
  assign bus.d_inst_o  = inst_mem[rd_ptr];
  assign bus.d_pc_o    = pc_mem[rd_ptr];
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc     <= RESET_PC;
      run    <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      run <= 1'b1;
      if (bus.redir_i) begin
        // Redirect drops everything in flight, including a coincident ack or pop.
        pc     <= bus.redir_adr_i;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc <= pc + 1'b1;
        end
        if (wr_en) begin
          inst_mem[wr_ptr] <= bus.f_dat_i;
          pc_mem[wr_ptr]   <= pc;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({wr_en, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stage_f_queue.sv
// tb/tb_stage_f_queue.sv - scoreboard bench for stage_f_queue: streaming, wait states, full, redirect, reset, wrap.
module tb_stage_f_queue;
  logic clk = 1'b0;
  logic reset_i;
  logic rst2;
  always #5 clk = ~clk;

  stage_f_queue_if #(.ADR_WIDTH(64)) b ();
  stage_f_queue_if #(.ADR_WIDTH(64)) b2 ();

  stage_f_queue dut (.clk_i(clk), .reset_i(reset_i), .bus(b.master));
  stage_f_queue #(.RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (.clk_i(clk), .reset_i(rst2), .bus(b2.master));

  localparam logic [61:0] W0 = 62'h3FFF_FFFF_FFFF_FFC0;
  localparam logic [61:0] RA = 62'h400;

  int checks = 0;
  int errors = 0;
  logic done2 = 1'b0;
  logic [31:0] dat_n = 32'hD000_0000;
  logic [93:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, record expected pushes, check register outputs, advance.
  task automatic cyc(input logic rst, input logic ack, input logic rdy, input logic rd,
                     input logic [61:0] radr, input logic ecyc, input logic [61:0] eadr,
                     input int ev);
    reset_i       = rst;
    b.f_ack_i     = ack;
    b.d_ready_i   = rdy;
    b.redir_i     = rd;
    b.redir_adr_i = radr;
    b.f_dat_i     = dat_n;
    if (rd || rst) sb.delete();
    else if (ecyc && ack) sb.push_back({dat_n, eadr});
    dat_n = dat_n + 32'h11;
    #1;
    chk("f_cyc", {63'd0, b.f_cyc_o}, {63'd0, ecyc});
    chk("f_adr", {2'b0, b.f_adr_o}, {2'b0, eadr});
    if (ev >= 0) chk("d_valid", {63'd0, b.d_valid_o}, 64'(ev));
    @(posedge clk);
    #1;
  endtask

  task automatic sb_drained(input string name);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every accepted head must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_i === 1'b0 && b.redir_i === 1'b0 && b.d_valid_o === 1'b1 && b.d_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual pc=%h required=none", b.d_pc_o);
      end else begin
        logic [93:0] e;
        e = sb.pop_front();
        chk("d_inst", {32'd0, b.d_inst_o}, {32'd0, e[93:62]});
        chk("d_pc", {2'b0, b.d_pc_o}, {2'b0, e[61:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Second instance: word address wraps from all-ones to zero.
  initial begin
    rst2 = 1'b1;
    b2.f_ack_i = 1'b0;
    b2.d_ready_i = 1'b1;
    b2.redir_i = 1'b0;
    b2.redir_adr_i = '0;
    b2.f_dat_i = 32'h1234_5678;
    @(posedge clk); #1;
    chk("wrap_rst_cyc", {63'd0, b2.f_cyc_o}, 64'd0);
    chk("wrap_rst_adr", {2'b0, b2.f_adr_o}, 64'h3FFF_FFFF_FFFF_FFFF);
    rst2 = 1'b0;
    b2.f_ack_i = 1'b1;
    @(posedge clk); #1;
    chk("wrap_cyc", {63'd0, b2.f_cyc_o}, 64'd1);
    chk("wrap_adr0", {2'b0, b2.f_adr_o}, 64'h3FFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    chk("wrap_adr1", {2'b0, b2.f_adr_o}, 64'd0);
    @(posedge clk); #1;
    chk("wrap_adr2", {2'b0, b2.f_adr_o}, 64'd1);
    done2 = 1'b1;
  end

  initial begin
    reset_i = 1'b1;
    b.f_ack_i = 1'b0;
    b.d_ready_i = 1'b0;
    b.redir_i = 1'b0;
    b.redir_adr_i = '0;
    b.f_dat_i = '0;
    @(posedge clk); #1;

    // Streaming with a two-clock wait state on the second word.
    cyc(1, 1, 1, 0, 0, 0, W0, 0);
    cyc(0, 1, 1, 0, 0, 0, W0, -1);
    cyc(0, 1, 1, 0, 0, 1, W0, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd1, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd1, -1);
    cyc(0, 1, 1, 0, 0, 1, W0 + 62'd1, -1);
    cyc(0, 1, 1, 0, 0, 1, W0 + 62'd2, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd3, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd3, 0);
    sb_drained("stream_drained");

    // Fill to DEPTH with decode stalled, then release one slot.
    cyc(1, 0, 0, 0, 0, 1, W0 + 62'd3, -1);
    cyc(0, 0, 0, 0, 0, 0, W0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1, W0 + 62'(i), -1);
    cyc(0, 1, 0, 0, 0, 0, W0 + 62'd4, 1);
    cyc(0, 1, 1, 0, 0, 0, W0 + 62'd4, 1);
    cyc(0, 0, 0, 0, 0, 1, W0 + 62'd4, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1, W0 + 62'd4, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd4, 0);
    sb_drained("full_drained");

    // Redirect with three queued entries and a coincident ack.
    cyc(1, 0, 0, 0, 0, 1, W0 + 62'd4, -1);
    cyc(0, 0, 0, 0, 0, 0, W0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1, W0 + 62'(i), -1);
    cyc(0, 1, 0, 1, RA, 1, W0 + 62'd3, 1);
    cyc(0, 0, 1, 0, 0, 1, RA, 0);
    cyc(0, 1, 1, 0, 0, 1, RA, -1);
    cyc(0, 0, 1, 0, 0, 1, RA + 62'd1, -1);
    cyc(0, 0, 1, 0, 0, 1, RA + 62'd1, 0);
    sb_drained("redir_drained");

    // Reset while two entries are queued and an ack is present.
    cyc(1, 0, 0, 0, 0, 1, RA + 62'd1, -1);
    cyc(0, 0, 0, 0, 0, 0, W0, 0);
    cyc(0, 1, 0, 0, 0, 1, W0, -1);
    cyc(0, 1, 0, 0, 0, 1, W0 + 62'd1, -1);
    cyc(1, 1, 0, 0, 0, 1, W0 + 62'd2, 1);
    cyc(0, 1, 1, 0, 0, 0, W0, 0);
    cyc(0, 1, 1, 0, 0, 1, W0, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd1, -1);
    cyc(0, 0, 1, 0, 0, 1, W0 + 62'd1, 0);
    sb_drained("reset_drained");

    for (int i = 0; i < 100 && !done2; i++) @(posedge clk);
    if (!done2) begin
      checks++;
      errors++;
      $display("FAIL wrap_done actual=0 required=1");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_f_queue.md
Name: stage_f_queue

Overview:
Parametrised successor to the single-word instruction fetch stage. Fetches sequential 32-bit instruction words over the F-bus and buffers them with their PCs in a DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready handshake. A redirect port (branch/trap) restarts fetch at a new address and flushes stale words.

Parameters:
ADR_WIDTH, 64, byte-address width; bus carries word address [ADR_WIDTH-1:2]
RESET_VECTOR, 64'hFFFF_FFFF_FFFF_FF00, byte address of first fetch after reset; bits [1:0] ignored
DEPTH, 4, queue entries; power of two, >= 2
DEPTH_LOG2, 2, log2(DEPTH)

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  reset: one clock; synchronous, active-high
f_cyc_o  out  1  F-bus cycle request
f_ack_i  in  1  F-bus acknowledge; f_dat_i valid in the same cycle
f_adr_o  out  ADR_WIDTH-2  fetch word address [ADR_WIDTH-1:2]
f_dat_i  in  32  fetched instruction word
redir_i  in  1  redirect request
redir_adr_i  in  ADR_WIDTH-2  redirect word address
d_valid_o  out  1  queue head valid
d_ready_i  in  1  decode accepts head
d_inst_o  out  32  head instruction
d_pc_o  out  ADR_WIDTH-2  head word address

Behaviour:
- State:
  - pc register (ADR_WIDTH-2 bits).
  - run flag.
  - Circular buffer of DEPTH {inst, pc} entries.
  - rd_ptr and wr_ptr (DEPTH_LOG2 bits).
  - count (DEPTH_LOG2+1 bits).
- Reset (reset_i=1 at edge):
  - pc <= RESET_VECTOR[ADR_WIDTH-1:2]; run <= 0; pointers and count <= 0.
  - Outputs after the edge: f_cyc_o=0, d_valid_o=0, f_adr_o=RESET_VECTOR>>2.
  - Reset mid-transfer abandons the cycle; no ack is ever consumed in a reset cycle.
  - Reset has priority over every other input.
- run <= 1 on the first edge with reset_i=0. f_cyc_o is asserted the cycle after reset releases.
- f_cyc_o = run & (count != DEPTH), a function of registers only; there is no combinational path from d_ready_i.
- f_adr_o = pc. It is held stable while f_cyc_o=1 and f_ack_i=0; wait states are unbounded.
- Push: f_cyc_o & f_ack_i & ~redir_i at edge.
  - Writes {f_dat_i, pc} at wr_ptr; wr_ptr++.
  - pc <= pc+1 (next byte address +4), wrapping modulo 2^(ADR_WIDTH-2).
  - Back-to-back acks give one word per clock.
- Pop: d_valid_o & d_ready_i & ~redir_i at edge; rd_ptr++.
- d_valid_o = (count != 0); d_inst_o/d_pc_o come from the entry at rd_ptr.
- Ack-to-d_valid_o latency is 1 clock.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap naturally at DEPTH.
- Full (count==DEPTH): f_cyc_o=0; a pop re-enables f_cyc_o on the following cycle.
- Empty: d_valid_o=0; d_ready_i is ignored.
- Redirect (redir_i=1 at edge, reset_i=0):
  - count, rd_ptr, wr_ptr <= 0; pc <= redir_adr_i.
  - A coincident ack is discarded and its pc increment is suppressed; a coincident pop is discarded.
  - d_valid_o=0 the next cycle.
  - f_cyc_o stays asserted if run=1, presenting redir_adr_i the next cycle.
- Outputs are undefined (X-free but don't-care) only in entries not yet written; d_inst_o is don't-care while d_valid_o=0.

Optional Feature:
STAGE_F_BYPASS_EN
- Defined: when count==0 and a push occurs, d_valid_o is asserted combinationally in the same cycle, with d_inst_o=f_dat_i and d_pc_o=f_adr_o.
  - If d_ready_i=1 in that cycle, the word is consumed and not written; count stays 0.
  - Otherwise it is written normally.
  - Latency from ack to decode is 0 clocks.
- Undefined: no bypass; latency is 1 clock as described above.

Test Plan:
- Reset, then release; hold f_ack_i=1, d_ready_i=1:
  - f_cyc_o=0 during reset.
  - Next cycle f_adr_o=FFFF_FFFF_FFFF_FF00, then FF04, FF08 on successive clocks.
  - d_pc_o lags by 1 (0 with bypass).
- Wait states: drop f_ack_i for 2 clocks at FF04 -> f_adr_o holds FF04 with f_cyc_o=1; it advances to FF08 the clock after f_ack_i returns, and no duplicate entry appears.
- Full: d_ready_i=0, f_ack_i=1 -> after 4 pushes count=4 and f_cyc_o=0; one pop -> f_cyc_o=1 the next cycle; popped order is FF00, FF04, FF08, FF0C with matching f_dat_i.
- Redirect: with 3 entries queued, pulse redir_i with redir_adr_i=0x1000>>2 while f_ack_i=1 -> d_valid_o=0 next cycle; the next fetch is 0x1000 and the acked word in the redirect cycle never appears.
- Wrap-around: RESET_VECTOR=FFFF_FFFF_FFFF_FFFC, ack twice -> addresses FFFC then 0000_0000_0000_0000.
- Reset mid-operation: assert reset_i with count=2 and f_ack_i=1 -> next cycle d_valid_o=0, f_cyc_o=0, f_adr_o=FF00.
